lfsr_rng: RTL and testbench

- Parametrised successor to the single-bit gameplay LFSR: configurable width and taps, and several steps per advance (leap-forward).
- Adds seed loading, all-zero lockup recovery and entropy injection.
- Adds a req/valid range generator that returns a uniform value in [0, limit) by rejection sampling.
- Feeds asteroid spawn position, heading and UFO timing logic from one shared source.

---
 rtl/lfsr_rng_if.sv | 33 +++
 rtl/lfsr_rng.sv | 165 ++++++++++++++++
 tb/tb_lfsr_rng.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_rng_if.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_rng_if
// Description : Seed, advance, entropy and range-request bundle for lfsr_rng.
// Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_rng_if #(
    parameter int WIDTH = 10,
    parameter int OUT_W = 8
);
    logic             seed_load;
    logic [WIDTH-1:0] seed;
    logic             en;
    logic             din;
    logic             req;
    logic [OUT_W-1:0] limit;
    logic             busy;
    logic             valid;
    logic [OUT_W-1:0] value;
    logic             fallback;
    logic [WIDTH-1:0] state;

    modport master (
        output seed_load, seed, en, din, req, limit,
        input  busy, valid, value, fallback, state
    );

    modport slave (
        input  seed_load, seed, en, din, req, limit,
        output busy, valid, value, fallback, state
    );
endinterface
`default_nettype wire

// File: rtl/lfsr_rng.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_rng
// Description : Leap-forward Fibonacci LFSR with seed load, lockup recovery,
//               entropy injection and a rejection-sampling range generator.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_rng #(
    parameter int               WIDTH     = 10,
    parameter logic [WIDTH-1:0] TAPS      = 'h240,
    parameter int               STEPS     = 1,
    parameter int               OUT_W     = 8,
    parameter int               MAX_TRIES = 4
) (
    input  logic      clk,
    input  logic      init,
    lfsr_rng_if.slave bus
);

    localparam int               c_TRY_W      = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [c_TRY_W-1:0] c_LAST_TRY = c_TRY_W'(MAX_TRIES - 1);
    localparam logic [WIDTH-1:0] c_RESET_STATE = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [0:0]       c_S_IDLE     = 1'b0;
    localparam logic [0:0]       c_S_DRAW     = 1'b1;

    generate
        if (OUT_W > WIDTH || STEPS < 1 || STEPS > WIDTH || WIDTH < 3 || MAX_TRIES < 1) begin : g_param_check
            $error("lfsr_rng: illegal parameter combination");
        end
    endgenerate

    logic [WIDTH-1:0]   r_state;
    logic [0:0]         r_fsm;
    logic [OUT_W-1:0]   r_lim;
    logic [OUT_W-1:0]   r_mask;
    logic [c_TRY_W-1:0] r_tries;
    logic [OUT_W-1:0]   r_value;
    logic               r_valid;
    logic               r_fallback;

    logic [WIDTH-1:0]   w_chain;
    logic               w_fb;
    logic [WIDTH-1:0]   w_adv_state;
    logic [WIDTH-1:0]   w_seed_state;
    logic               w_advance;
    logic [OUT_W-1:0]   w_lim_m1;
    logic [OUT_W-1:0]   w_mask_in;
    logic [OUT_W-1:0]   w_cand;
    logic               w_accept;

    logic [WIDTH-1:0]   w_state_nxt;
    logic [0:0]         w_fsm_nxt;
    logic [OUT_W-1:0]   w_lim_nxt;
    logic [OUT_W-1:0]   w_mask_nxt;
    logic [c_TRY_W-1:0] w_tries_nxt;
    logic [OUT_W-1:0]   w_value_nxt;
    logic               w_valid_nxt;
    logic               w_fallback_nxt;

    // Leap-forward: STEPS shifts unrolled; entropy only enters the first one.
    always_comb begin
        w_chain = r_state;
        w_fb    = 1'b0;
        for (int i = 0; i < STEPS; i++) begin
            w_fb    = (^(w_chain & TAPS)) ^ ((i == 0) ? bus.din : 1'b0);
            w_chain = {w_chain[WIDTH-2:0], w_fb};
        end
    end

    assign w_adv_state  = (w_chain == '0) ? c_RESET_STATE : w_chain;
    assign w_seed_state = (bus.seed == '0) ? c_RESET_STATE : bus.seed;
    assign w_advance    = bus.en | (r_fsm == c_S_DRAW);

    // Mask bit i is set when limit-1 reaches 2^i; limit 0 keeps every bit.
    always_comb begin
        w_lim_m1  = bus.limit - 1'b1;
        w_mask_in = '0;
        if (bus.limit == '0) begin
            w_mask_in = '1;
        end else begin
            for (int i = 0; i < OUT_W; i++) begin
                w_mask_in[i] = |(w_lim_m1 >> i);
            end
        end
    end

    assign w_cand   = w_adv_state[OUT_W-1:0] & r_mask;
    assign w_accept = (r_lim == '0) || (w_cand < r_lim);

    always_comb begin
        w_fsm_nxt      = r_fsm;
        w_lim_nxt      = r_lim;
        w_mask_nxt     = r_mask;
        w_tries_nxt    = r_tries;
        w_value_nxt    = r_value;
        w_valid_nxt    = 1'b0;
        w_fallback_nxt = r_fallback;
        w_state_nxt    = r_state;

        if (bus.seed_load) begin
            w_state_nxt = w_seed_state;
        end else begin
            if (w_advance) begin
                w_state_nxt = w_adv_state;
            end
            case (r_fsm)
                c_S_IDLE: begin
                    if (bus.req) begin
                        w_lim_nxt   = bus.limit;
                        w_mask_nxt  = w_mask_in;
                        w_tries_nxt = '0;
                        w_fsm_nxt   = c_S_DRAW;
                    end
                end
                c_S_DRAW: begin
                    if (w_accept) begin
                        w_value_nxt    = w_cand;
                        w_fallback_nxt = 1'b0;
                        w_valid_nxt    = 1'b1;
                        w_fsm_nxt      = c_S_IDLE;
                    end else if (r_tries == c_LAST_TRY) begin
                        // cand < 2*lim-1 here, so the fold stays below lim.
                        w_value_nxt    = w_cand - r_lim;
                        w_fallback_nxt = 1'b1;
                        w_valid_nxt    = 1'b1;
                        w_fsm_nxt      = c_S_IDLE;
                    end else begin
                        w_tries_nxt = r_tries + c_TRY_W'(1);
                    end
                end
                default: w_fsm_nxt = c_S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            r_state    <= c_RESET_STATE;
            r_fsm      <= c_S_IDLE;
            r_lim      <= '0;
            r_mask     <= '0;
            r_tries    <= '0;
            r_value    <= '0;
            r_valid    <= 1'b0;
            r_fallback <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fsm      <= w_fsm_nxt;
            r_lim      <= w_lim_nxt;
            r_mask     <= w_mask_nxt;
            r_tries    <= w_tries_nxt;
            r_value    <= w_value_nxt;
            r_valid    <= w_valid_nxt;
            r_fallback <= w_fallback_nxt;
        end
    end

    assign bus.busy     = (r_fsm != c_S_IDLE);
    assign bus.valid    = r_valid;
    assign bus.value    = r_value;
    assign bus.fallback = r_fallback;
    assign bus.state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_rng.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_rng
// Description : Self-checking bench for lfsr_rng against a cycle model of
//               x^10+x^7+1 plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_rng;

    logic clk;
    logic init;
    int   n_vec;
    int   n_bad;
    logic chk_en;

    lfsr_rng_if #(.WIDTH(10), .OUT_W(8)) bus_a ();
    lfsr_rng_if #(.WIDTH(10), .OUT_W(8)) bus_b ();
    lfsr_rng_if #(.WIDTH(10), .OUT_W(8)) bus_c ();

    lfsr_rng #(.WIDTH(10), .TAPS(10'h240), .STEPS(1), .OUT_W(8), .MAX_TRIES(4))
        dut_a (.clk(clk), .init(init), .bus(bus_a.slave));
    lfsr_rng #(.WIDTH(10), .TAPS(10'h240), .STEPS(3), .OUT_W(8), .MAX_TRIES(4))
        dut_b (.clk(clk), .init(init), .bus(bus_b.slave));
    lfsr_rng #(.WIDTH(10), .TAPS(10'h240), .STEPS(1), .OUT_W(8), .MAX_TRIES(1))
        dut_c (.clk(clk), .init(init), .bus(bus_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_between(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // ---------------- reference model for dut_a (x^10 + x^7 + 1) -------------
    logic [9:0] m_state;
    logic       m_busy, m_valid, m_fb;
    logic [7:0] m_value, m_lim, m_mask;
    int         m_tries;

    function automatic logic [9:0] model_step(input logic [9:0] s, input logic d);
        logic b;
        b = s[9] ^ s[6] ^ d;
        return {s[8:0], b};
    endfunction

    function automatic logic [7:0] mask_of(input int lim);
        int m;
        if (lim == 0) return 8'hFF;
        m = 0;
        while (m < lim - 1) m = m * 2 + 1;
        return m[7:0];
    endfunction

    always @(posedge clk) begin
        logic [9:0] nxt;
        logic [7:0] cand;
        if (init) begin
            m_state = 10'h200; m_busy = 0; m_valid = 0; m_fb = 0;
            m_value = 0; m_lim = 0; m_mask = 0; m_tries = 0;
        end else begin
            m_valid = 0;
            if (bus_a.seed_load) begin
                m_state = (bus_a.seed == 0) ? 10'h200 : bus_a.seed;
            end else begin
                nxt = model_step(m_state, bus_a.din);
                if (nxt == 0) nxt = 10'h200;
                if (m_busy) begin
                    cand    = nxt[7:0] & m_mask;
                    m_state = nxt;
                    if (m_lim == 0 || cand < m_lim) begin
                        m_value = cand; m_fb = 0; m_valid = 1; m_busy = 0;
                    end else if (m_tries == 3) begin
                        m_value = cand - m_lim; m_fb = 1; m_valid = 1; m_busy = 0;
                    end else begin
                        m_tries++;
                    end
                end else begin
                    if (bus_a.en) m_state = nxt;
                    if (bus_a.req) begin
                        m_lim = bus_a.limit; m_mask = mask_of(int'(bus_a.limit));
                        m_tries = 0; m_busy = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_state", 32'(bus_a.state), 32'(m_state));
            check("model_busy", 32'(bus_a.busy), 32'(m_busy));
            check("model_valid", 32'(bus_a.valid), 32'(m_valid));
            check("model_value", 32'(bus_a.value), 32'(m_value));
            if (bus_a.valid) check("model_fallback", 32'(bus_a.fallback), 32'(m_fb));
        end
    end

    task automatic draw(input logic [7:0] lim, output logic [7:0] val, output logic fb, output int lat);
        bus_a.limit = lim;
        bus_a.req   = 1'b1;
        tick();
        bus_a.req = 1'b0;
        lat = 1;
        while (!bus_a.valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!bus_a.valid) begin
            n_vec++;
            n_bad++;
            $display("FAIL draw_timeout: got no valid, expected valid within 20 cycles");
        end
        val = bus_a.value;
        fb  = bus_a.fallback;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] v;
        logic       f;
        int         lat;
        int         first_ret;
        int         distinct;
        int         nv;
        bit         seen [1024];
        int         bucket [100];

        n_vec = 0; n_bad = 0; chk_en = 0;
        init = 1'b1;
        bus_a.seed_load = 0; bus_a.seed = 0; bus_a.en = 0; bus_a.din = 0; bus_a.req = 0; bus_a.limit = 0;
        bus_b.seed_load = 0; bus_b.seed = 0; bus_b.en = 0; bus_b.din = 0; bus_b.req = 0; bus_b.limit = 0;
        bus_c.seed_load = 0; bus_c.seed = 0; bus_c.en = 0; bus_c.din = 0; bus_c.req = 0; bus_c.limit = 0;
        tick(); tick();
        init = 1'b0;
        chk_en = 1;

        check("reset_state", 32'(bus_a.state), 32'h200);
        check("reset_busy", 32'(bus_a.busy), 0);
        check("reset_valid", 32'(bus_a.valid), 0);
        check("reset_value", 32'(bus_a.value), 0);
        check("reset_fallback", 32'(bus_a.fallback), 0);
        check("reset_state_b", 32'(bus_b.state), 32'h200);

        // Maximal-length period.
        first_ret = 0; distinct = 0;
        bus_a.en = 1;
        for (int i = 1; i <= 1023; i++) begin
            tick();
            if (i == 1) check("first_step", 32'(bus_a.state), 32'h001);
            if (i == 3) check("third_step", 32'(bus_a.state), 32'h004);
            if (bus_a.state == 10'h200 && first_ret == 0) first_ret = i;
            if (!seen[bus_a.state]) begin
                seen[bus_a.state] = 1;
                distinct++;
            end
        end
        bus_a.en = 0;
        check("period", 32'(first_ret), 1023);
        check("distinct_states", 32'(distinct), 1023);

        // Seed loading.
        bus_a.seed_load = 1; bus_a.seed = 10'h000;
        tick();
        check("seed_zero", 32'(bus_a.state), 32'h200);
        bus_a.seed = 10'h155; bus_a.en = 1;
        tick();
        check("seed_beats_en", 32'(bus_a.state), 32'h155);
        bus_a.seed_load = 0; bus_a.en = 0;

        // Leap-forward by three vs three single steps.
        bus_a.seed_load = 1; bus_a.seed = 10'h001;
        bus_b.seed_load = 1; bus_b.seed = 10'h001;
        tick();
        bus_a.seed_load = 0; bus_b.seed_load = 0;
        bus_a.en = 1; bus_b.en = 1;
        tick();
        bus_b.en = 0;
        tick(); tick();
        bus_a.en = 0;
        check("steps3_state", 32'(bus_b.state), 32'h008);
        check("steps1_x3_state", 32'(bus_a.state), 32'h008);
        check("steps3_vs_steps1", 32'(bus_b.state), 32'(bus_a.state));

        for (int i = 0; i < 3; i++) begin
            draw(8'd1, v, f, lat);
            check("limit1_value", 32'(v), 0);
        end

        bus_a.seed_load = 1; bus_a.seed = 10'h155;
        tick();
        bus_a.seed_load = 0;
        draw(8'd0, v, f, lat);
        check("limit0_latency", 32'(lat), 2);
        check("limit0_value", 32'(v), 32'hAB);
        check("limit0_fallback", 32'(f), 0);

        // en during the draw must still give one advance per edge.
        bus_a.seed_load = 1; bus_a.seed = 10'h155;
        tick();
        bus_a.seed_load = 0; bus_a.en = 1;
        draw(8'd0, v, f, lat);
        bus_a.en = 0;
        check("en_draw_value", 32'(v), 32'h57);
        check("en_draw_latency", 32'(lat), 2);

        foreach (bucket[b]) bucket[b] = 0;
        for (int i = 0; i < 5000; i++) begin
            draw(8'd100, v, f, lat);
            check_between("limit100_range", int'(v), 0, 99);
            if (v < 100) bucket[v]++;
        end
        foreach (bucket[b]) check_between("limit100_bucket", bucket[b], 30, 70);

        // MAX_TRIES=1 fallback: candidate 200 folds to 71.
        bus_c.seed_load = 1; bus_c.seed = 10'h264;
        tick();
        bus_c.seed_load = 0;
        bus_c.limit = 8'd129; bus_c.req = 1;
        tick();
        check("c_busy", 32'(bus_c.busy), 1);
        check("c_valid_early", 32'(bus_c.valid), 0);
        tick();
        check("c_valid", 32'(bus_c.valid), 1);
        check("c_value", 32'(bus_c.value), 71);
        check("c_fallback", 32'(bus_c.fallback), 1);
        check("c_busy_fall", 32'(bus_c.busy), 0);
        bus_c.req = 0;
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus_c.valid) nv++;
        end
        check("c_no_extra_valid", 32'(nv), 0);

        // init in the middle of a draw.
        bus_a.limit = 8'd0; bus_a.req = 1;
        tick();
        check("init_pre_busy", 32'(bus_a.busy), 1);
        init = 1; bus_a.req = 0;
        tick();
        init = 0;
        check("init_busy", 32'(bus_a.busy), 0);
        check("init_valid", 32'(bus_a.valid), 0);
        check("init_state", 32'(bus_a.state), 32'h200);
        nv = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus_a.valid) nv++;
        end
        check("init_discard", 32'(nv), 0);
        draw(8'd0, v, f, lat);
        check("post_init_value", 32'(v), 32'h01);
        check("post_init_latency", 32'(lat), 2);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
